pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank_pkg.sv | 16 +
 rtl/pwm_timebase.sv | 40 ++++
 rtl/pwm_bank.sv | 97 +++++++++
 tb/tb_pwm_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// Shared constants for the PWM bank: register map and legal parameter ranges.
package pwm_bank_pkg;

   localparam logic [7:0] ADDR_EN_LO     = 8'h00;
   localparam logic [7:0] ADDR_EN_HI     = 8'h01;
   localparam logic [7:0] ADDR_MODE_LO   = 8'h02;
   localparam logic [7:0] ADDR_MODE_HI   = 8'h03;
   localparam logic [7:0] ADDR_PRESC     = 8'h04;
   localparam logic [7:0] ADDR_DUTY_BASE = 8'h10;

   localparam int NUM_CH_MIN = 1;
   localparam int NUM_CH_MAX = 16;
   localparam int CNT_W_MIN  = 4;
   localparam int CNT_W_MAX  = 8;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus period counter shared by every PWM channel.
module pwm_timebase
   import pwm_bank_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [7:0]       presc,
   input  logic             presc_clr,
   output logic [CNT_W-1:0] cnt,
   output logic             tick,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [7:0] pre_cnt;

   assign tick = ena && (pre_cnt == presc);
   // wrap marks the last count; the period ends on the tick taken there
   assign wrap = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         cnt     <= '0;
      end else if (ena) begin
         if (presc_clr || tick) pre_cnt <= '0;
         else                   pre_cnt <= pre_cnt + 8'd1;
         if (tick) begin
            if (wrap) cnt <= '0;
            else      cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one timebase, configured by byte writes.
module pwm_bank
   import pwm_bank_pkg::*;
#(
   parameter int NUM_CH = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_addr,
   input  logic [7:0]        wr_data,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [NUM_CH-1:0] pwm_oe,
   output logic              period_tick
);

   logic             wr_en;
   logic             presc_clr;
   logic [7:0]       presc;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic             wrap;
   logic             period_end;
   logic             tick_p1;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] out_p1;

   assign wr_ready   = ena;
   assign wr_en      = wr_valid && ena;
   assign presc_clr  = wr_en && (wr_addr == ADDR_PRESC);
   assign period_end = tick && wrap;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc   <= '0;
         tick_p1 <= 1'b0;
      end else begin
         if (presc_clr) presc <= wr_data;
         tick_p1 <= period_end;
      end
   end

   pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .presc     (presc),
      .presc_clr (presc_clr),
      .cnt       (cnt),
      .tick      (tick),
      .wrap      (wrap)
   );

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam logic [7:0] EN_ADDR   = (k < 8) ? ADDR_EN_LO : ADDR_EN_HI;
      localparam logic [7:0] MODE_ADDR = (k < 8) ? ADDR_MODE_LO : ADDR_MODE_HI;
      localparam logic [7:0] DUTY_ADDR = ADDR_DUTY_BASE + 8'(k);
      localparam int         BIT       = k % 8;

      logic [CNT_W-1:0] shadow;
      logic [CNT_W-1:0] active;
      logic             en_r;
      logic             mode_r;
      logic             out_r;
      logic             duty_wr;

      assign duty_wr = wr_en && (wr_addr == DUTY_ADDR);

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            en_r   <= 1'b0;
            mode_r <= 1'b0;
            out_r  <= 1'b0;
         end else begin
            if (wr_en && (wr_addr == EN_ADDR))   en_r   <= wr_data[BIT];
            if (wr_en && (wr_addr == MODE_ADDR)) mode_r <= wr_data[BIT];
            if (duty_wr) shadow <= wr_data[CNT_W-1:0];
            // a write landing on the wrap goes straight into the active duty
            if (period_end) active <= duty_wr ? wr_data[CNT_W-1:0] : shadow;
            if (ena) out_r <= en_r && (!mode_r || (cnt < active));
         end
      end

      assign en[k]     = en_r;
      assign out_p1[k] = out_r;
   end

   assign pwm_out     = out_p1 & {NUM_CH{ena}};
   assign pwm_oe      = en & {NUM_CH{ena}};
   assign period_tick = tick_p1 && ena;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank (4 channels, 8-bit counter): measures high time and period per channel.
module tb_pwm_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] pwm_out;
   logic [3:0] pwm_oe;
   logic       period_tick;

   int n_run  = 0;
   int n_fail = 0;
   int hi, per;

   always #5 clk = ~clk;

   pwm_bank #(.NUM_CH(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .pwm_out     (pwm_out),
      .pwm_oe      (pwm_oe),
      .period_tick (period_tick)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (period_tick) ok = 1'b1;
      end
   endtask

   // hold ena low for 50 cycles, trying a write that must be refused
   task automatic freeze();
      ena      = 1'b0;
      wr_valid = 1'b1;
      wr_addr  = 8'h11;
      wr_data  = 8'h10;
      @(negedge clk);
      wr_valid = 1'b0;
      check("frz_pwm_out", pwm_out, 0);
      check("frz_pwm_oe", pwm_oe, 0);
      check("frz_tick", period_tick, 0);
      check("frz_wr_ready", wr_ready, 0);
      repeat (49) @(negedge clk);
      ena = 1'b1;
   endtask

   // one period from a period_tick to the next; optional write or freeze at sample index
   task automatic measure(input int ch, input bit sync, input int wr_at,
                          input logic [7:0] wa, input logic [7:0] wd, input int frz_at,
                          output int h, output int p);
      bit ok;
      bit done;
      if (sync) begin
         wait_tick(ok);
         check("tick_wait", ok, 1);
      end
      h    = 0;
      p    = 0;
      done = 1'b0;
      while (!done && p < 2000) begin
         @(negedge clk);
         wr_valid = 1'b0;
         p++;
         if (pwm_out[ch]) h++;
         if (period_tick) done = 1'b1;
         else begin
            if (p == wr_at) begin
               wr_valid = 1'b1;
               wr_addr  = wa;
               wr_data  = wd;
            end
            if (p == frz_at) freeze();
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      check("rst_pwm_out", pwm_out, 0);
      check("rst_pwm_oe", pwm_oe, 0);
      check("rst_tick", period_tick, 0);
      check("rst_wr_ready", wr_ready, 1);
      rst_n = 1'b1;

      // 50% duty on channel 0
      wr(8'h04, 8'h00); wr(8'h00, 8'h01); wr(8'h02, 8'h01); wr(8'h10, 8'h80);
      check("oe_ch0", pwm_oe, 4'h1);
      measure(0, 1, -1, 8'h0, 8'h0, -1, hi, per);
      check("d80_hi", hi, 128);
      check("d80_per", per, 255);
      measure(0, 0, -1, 8'h0, 8'h0, -1, hi, per);
      check("d80_spacing", per, 255);
      check("d80_hi2", hi, 128);

      // duty extremes, always-on mode, disable
      wr(8'h10, 8'h00);
      measure(0, 1, -1, 8'h0, 8'h0, -1, hi, per);
      check("d00_hi", hi, 0);
      wr(8'h10, 8'hFF);
      measure(0, 1, -1, 8'h0, 8'h0, -1, hi, per);
      check("dff_hi", hi, 255);
      wr(8'h10, 8'h00); wr(8'h02, 8'h00);
      measure(0, 1, -1, 8'h0, 8'h0, -1, hi, per);
      check("mode0_hi", hi, 255);
      wr(8'h00, 8'h00);
      measure(0, 1, -1, 8'h0, 8'h0, -1, hi, per);
      check("en0_hi", hi, 0);
      check("en0_oe", pwm_oe, 0);

      // shadow duty takes effect only at the wrap, except a write on the wrap
      wr(8'h00, 8'h01); wr(8'h02, 8'h01); wr(8'h10, 8'h40);
      measure(0, 1, -1, 8'h0, 8'h0, -1, hi, per);
      check("d40_hi", hi, 64);
      measure(0, 1, 16, 8'h10, 8'hC0, -1, hi, per);
      check("midwr_hi", hi, 64);
      check("midwr_per", per, 255);
      measure(0, 0, -1, 8'h0, 8'h0, -1, hi, per);
      check("dc0_hi", hi, 192);
      measure(0, 0, 254, 8'h10, 8'h20, -1, hi, per);
      check("wrapwr_hi", hi, 192);
      measure(0, 0, -1, 8'h0, 8'h0, -1, hi, per);
      check("wrapwr_next_hi", hi, 32);

      // prescaled period on channel 1
      wr(8'h00, 8'h02); wr(8'h02, 8'h02); wr(8'h11, 8'h80); wr(8'h04, 8'h03);
      check("oe_ch1", pwm_oe, 4'h2);
      measure(1, 1, -1, 8'h0, 8'h0, -1, hi, per);
      check("p3_hi", hi, 512);
      check("p3_per", per, 1020);

      // writes beyond NUM_CH are ignored; freeze resumes from held counters
      wr(8'h15, 8'h33); wr(8'h01, 8'hFF); wr(8'h03, 8'hFF);
      check("unmapped_oe", pwm_oe, 4'h2);
      measure(1, 1, -1, 8'h0, 8'h0, -1, hi, per);
      check("unmapped_hi", hi, 512);
      measure(1, 0, -1, 8'h0, 8'h0, 300, hi, per);
      check("frz_per", per, 1020);
      check("frz_hi", hi, 512);
      measure(1, 0, -1, 8'h0, 8'h0, -1, hi, per);
      check("frz_blocked_hi", hi, 512);

      // reset mid-period with all channels driving, pending shadows, and a write
      wr(8'h00, 8'h0F); wr(8'h02, 8'h00);
      @(negedge clk);
      check("all_on", pwm_out, 4'hF);
      wait_tick(hi[0]);
      wr(8'h10, 8'hFF); wr(8'h11, 8'hFF); wr(8'h12, 8'hFF); wr(8'h13, 8'hFF);
      @(negedge clk);
      rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 8'h00; wr_data = 8'h0F;
      @(negedge clk);
      rst_n = 1'b1; wr_valid = 1'b0;
      check("mrst_pwm_out", pwm_out, 0);
      check("mrst_pwm_oe", pwm_oe, 0);
      check("mrst_tick", period_tick, 0);
      wr(8'h00, 8'h01); wr(8'h02, 8'h01);
      measure(0, 1, -1, 8'h0, 8'h0, -1, hi, per);
      check("mrst_duty_hi", hi, 0);
      check("mrst_presc_per", per, 255);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
